mpu_capture_ctrl: RTL and testbench
===================================

# mpu_capture_ctrl

Sequencer between the I2C MPU reader (`mpu`) and the attitude pipeline. It generates a fixed sample-rate tick and issues one burst read per tick via `mpu_transfer`. It assembles the 12 returned bytes into a frame that is only ever presented complete, and flags overruns and stalled transfers. It replaces ad-hoc byte counting in the flight-control FSM; `frame_valid` directly drives `angle_start` and the gyro integration step.

## Interface
- `CLK_MAIN`, 50000000: clock frequency in Hz.
- `SAMPLE_HZ`, 500: sample rate. `TICK_DIV = CLK_MAIN/SAMPLE_HZ` must be at least 2.
- `NBYTES`, 12: bytes per frame, in the range 1..15 (ax, ay, az, gx, gy, gz, each big-endian).
- `TIMEOUT_CYC`, 200000: maximum cycles allowed in CAPTURE before abort. Must be at least 1.

- `clk`: in, 1. System clock.
- `rst_n`: in, 1. Asynchronous, active-low reset.
- `init_done`: in, 1. From `mpu`; level, high once device configuration is complete.
- `enable`: in, 1. Permits new captures.
- `data_avalid`: in, 1. From `mpu`; one-cycle strobe per received byte.
- `data`: in, 8. Byte qualified by `data_avalid`.
- `busy_now`: in, 1. From `mpu`; high while the I2C engine is active.
- `mpu_transfer`: out, 1. Request to `mpu`; held high for the whole capture.
- `frame_valid`: out, 1. One-cycle pulse; `frame_data` is new and complete.
- `frame_data`: out, NBYTES*8. Byte 0 occupies the top 8 bits (`[NBYTES*8-1 -: 8]`); byte NBYTES-1 occupies `[7:0]`.
- `frame_count`: out, 16. Completed frames; wraps from 0xFFFF to 0.
- `sample_overrun`: out, 1. One-cycle pulse when a tick arrives outside IDLE.
- `timeout_err`: out, 1. One-cycle pulse when a capture is aborted.
- `busy`: out, 1. High in any state other than WAIT_INIT or IDLE.

## Operation
- **Reset values.** All outputs are 0: `frame_data`, `frame_count`, `mpu_transfer`, the pulses, and `busy`. State is WAIT_INIT, the tick counter is 0, and the byte counter is 0.
- **Tick counter.** Held at 0 in WAIT_INIT. Otherwise it counts 0..TICK_DIV-1 and wraps; `tick` is asserted for the one cycle in which the count equals TICK_DIV-1. It free-runs regardless of `enable` and state.
- **WAIT_INIT.** Moves to IDLE when `init_done` = 1.
- **IDLE.** If `tick` and `enable`, go to CAPTURE. A tick with `enable` = 0 is ignored silently (no overrun).
- **CAPTURE.**
  - `mpu_transfer` = 1 and the timeout counter increments each cycle.
  - Each `data_avalid` writes `data` into shadow slot [byte_cnt] and increments byte_cnt.
  - When the strobe for byte NBYTES-1 is accepted, go to DONE.
  - If the timeout counter reaches TIMEOUT_CYC-1 without the final byte, go to ABORT.
  - If the final byte and the timeout coincide in the same cycle, the byte wins and the next state is DONE.
- **DONE (1 cycle).**
  - Copy the shadow buffer to `frame_data`.
  - Pulse `frame_valid`.
  - Increment `frame_count`.
  - Clear byte_cnt and the timeout counter.
  - Go to IDLE.
- **ABORT.**
  - Pulse `timeout_err` on entry only.
  - Drop `mpu_transfer`.
  - Clear byte_cnt.
  - Leave `frame_data` unchanged.
  - Stay in ABORT until `busy_now` = 0, then go to IDLE.
- **Overrun.** A `tick` in any state except WAIT_INIT and IDLE pulses `sample_overrun`. That tick is discarded, not queued.
- **Stray bytes.** `data_avalid` outside CAPTURE is ignored and has no effect on the shadow buffer or byte_cnt.
- **`enable` deasserted during CAPTURE.** The current frame completes normally; `enable` is evaluated only in IDLE.
- **`init_done` falls outside WAIT_INIT.** Go to WAIT_INIT immediately. Drop `mpu_transfer`, clear the counters, and keep `frame_data` and `frame_count`.
- **Reset mid-capture.** Everything returns to its reset value asynchronously. Any partial frame is never presented.

## Timing
- The state register, `mpu_transfer`, and all pulse outputs are registered.
- A tick in cycle T puts the block in CAPTURE with `mpu_transfer` = 1 in cycle T+1.
- When the final `data_avalid` is sampled in cycle N:
  - cycle N+1: `frame_valid` = 1, `frame_data` holds the new frame, `mpu_transfer` = 0, and the count has incremented;
  - cycle N+2: back in IDLE.
- When the timeout fires in cycle N:
  - cycle N+1: `timeout_err` = 1 and `mpu_transfer` = 0;
  - the block leaves ABORT on the first cycle `busy_now` is sampled 0.
- `frame_data` is stable between `frame_valid` pulses and never shows a partial frame.

## Test plan
Bench parameters: CLK_MAIN = 1000, SAMPLE_HZ = 10 (so TICK_DIV = 100), NBYTES = 12, TIMEOUT_CYC = 50.

- **Normal frame.** Raise `init_done`; feed bytes 0x01..0x0C, one every 3 cycles, after `mpu_transfer` rises. Required: `frame_valid` pulses once, 1 cycle after the 12th strobe; `frame_data` = 0x0102030405060708090A0B0C; `frame_count` = 1.
- **Timeout.** Feed only 5 bytes and hold `busy_now` = 1 for 20 further cycles. Required: `timeout_err` pulses 50 cycles after CAPTURE entry; `mpu_transfer` is 0 from the next cycle; IDLE is re-entered the cycle after `busy_now` = 0; `frame_data` is unchanged.
- **Overrun.** Delay all bytes past the next tick (start feeding 120 cycles after capture begins; no timeout with TIMEOUT_CYC = 200 for this case). Required: `sample_overrun` pulses exactly at the tick; a single `frame_valid` follows; no second capture starts until the tick after that.
- **Disable and stray bytes.** With `enable` = 0, inject `data_avalid` strobes in IDLE. Required: no `mpu_transfer`, no `frame_valid`. Dropping `enable` mid-capture still yields a complete frame.
- **Reset and init drop.** Assert `rst_n` low after byte 6. Required: all outputs are 0 immediately. After release, the next frame contains only new bytes. Dropping `init_done` mid-capture leads to WAIT_INIT with `mpu_transfer` = 0 and `frame_count` preserved.
- **Counter wrap.** Force `frame_count` to 0xFFFF and complete one frame. Required: `frame_count` = 0x0000.

Source files
------------

// File: rtl/mpu_capture_ctrl.sv
// Capture sequencer between the I2C MPU reader and the attitude pipeline: issues one
// burst read per sample tick and presents each NBYTES frame only once it is complete.
module mpu_capture_ctrl #(
    parameter int CLK_MAIN    = 50000000,
    parameter int SAMPLE_HZ   = 500,
    parameter int NBYTES      = 12,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_done,
    input  logic                  enable,
    input  logic                  data_avalid,
    input  logic [7:0]            data,
    input  logic                  busy_now,
    output logic                  mpu_transfer,
    output logic                  frame_valid,
    output logic [NBYTES*8-1:0]   frame_data,
    output logic [15:0]           frame_count,
    output logic                  sample_overrun,
    output logic                  timeout_err,
    output logic                  busy
);

    localparam int TICK_DIV = CLK_MAIN / SAMPLE_HZ;
    localparam int TW       = $clog2(TICK_DIV);
    localparam int OW       = $clog2(TIMEOUT_CYC + 1);
    localparam int FW       = NBYTES * 8;

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_CAPTURE,
        S_DONE,
        S_ABORT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_tick_cnt;
    logic [3:0]      r_byte_cnt;
    logic [OW-1:0]   r_to_cnt;
    logic [FW-1:0]   r_shadow;
    logic [FW-1:0]   w_frame;
    logic            w_tick;
    logic            w_last_byte;
    logic            w_timeout;
    logic            w_overrun;

    assign w_tick      = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_last_byte = (r_state == S_CAPTURE) && data_avalid && (r_byte_cnt == 4'(NBYTES - 1));
    assign w_timeout   = (r_state == S_CAPTURE) && (r_to_cnt == OW'(TIMEOUT_CYC - 1));
    assign w_overrun   = w_tick && (r_state inside {S_CAPTURE, S_DONE, S_ABORT});

    // The final byte is folded in here so the frame register loads in the same edge it arrives.
    always_comb begin
        w_frame      = r_shadow;
        w_frame[7:0] = data;
    end

    always_comb begin
        w_next = r_state;
        if (r_state != S_WAIT_INIT && !init_done) begin
            w_next = S_WAIT_INIT;
        end else begin
            case (r_state)
                S_WAIT_INIT: if (init_done)        w_next = S_IDLE;
                S_IDLE:      if (w_tick && enable) w_next = S_CAPTURE;
                S_CAPTURE: begin
                    if (w_last_byte)    w_next = S_DONE;
                    else if (w_timeout) w_next = S_ABORT;
                end
                S_DONE:      w_next = S_IDLE;
                S_ABORT:     if (!busy_now)        w_next = S_IDLE;
                default:     w_next = S_WAIT_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_WAIT_INIT;
            r_tick_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_WAIT_INIT || w_next == S_WAIT_INIT || w_tick)
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // Byte and timeout counters only live while a capture continues; any exit clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
            r_to_cnt   <= '0;
            r_shadow   <= '0;
        end else begin
            if (r_state == S_CAPTURE && w_next == S_CAPTURE) begin
                r_to_cnt <= r_to_cnt + OW'(1);
                if (data_avalid)
                    r_byte_cnt <= r_byte_cnt + 4'd1;
            end else begin
                r_to_cnt   <= '0;
                r_byte_cnt <= '0;
            end
            for (int i = 0; i < NBYTES; i++) begin
                if (r_state == S_CAPTURE && data_avalid && r_byte_cnt == 4'(i))
                    r_shadow[FW-1-8*i -: 8] <= data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_data     <= '0;
            frame_count    <= '0;
            frame_valid    <= 1'b0;
            mpu_transfer   <= 1'b0;
            timeout_err    <= 1'b0;
            sample_overrun <= 1'b0;
            busy           <= 1'b0;
        end else begin
            if (w_next == S_DONE) begin
                frame_data  <= w_frame;
                frame_count <= frame_count + 16'd1;
            end
            frame_valid    <= (w_next == S_DONE);
            mpu_transfer   <= (w_next == S_CAPTURE);
            timeout_err    <= (r_state == S_CAPTURE) && (w_next == S_ABORT);
            sample_overrun <= w_overrun;
            busy           <= !(w_next inside {S_WAIT_INIT, S_IDLE});
        end
    end

endmodule

// File: tb/tb_mpu_capture_ctrl.sv
// Directed bench for mpu_capture_ctrl: TICK_DIV = 100, NBYTES = 12; the main instance
// uses TIMEOUT_CYC = 50, a second one with TIMEOUT_CYC = 200 covers the overrun case.
module tb_mpu_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_done;
    logic        enable;
    logic        data_avalid;
    logic [7:0]  data;
    logic        busy_now;

    logic        mpuTransfer, frameValid, sampleOverrun, timeoutErr, busyOut;
    logic [95:0] frameData;
    logic [15:0] frameCount;
    logic        mpuTransfer2, frameValid2, sampleOverrun2, timeoutErr2, busyOut2;
    logic [95:0] frameData2;
    logic [15:0] frameCount2;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    mpu_capture_ctrl #(.CLK_MAIN(1000), .SAMPLE_HZ(10), .NBYTES(12), .TIMEOUT_CYC(50)) u_dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .enable(enable),
        .data_avalid(data_avalid), .data(data), .busy_now(busy_now),
        .mpu_transfer(mpuTransfer), .frame_valid(frameValid), .frame_data(frameData),
        .frame_count(frameCount), .sample_overrun(sampleOverrun),
        .timeout_err(timeoutErr), .busy(busyOut)
    );

    mpu_capture_ctrl #(.CLK_MAIN(1000), .SAMPLE_HZ(10), .NBYTES(12), .TIMEOUT_CYC(200)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .enable(enable),
        .data_avalid(data_avalid), .data(data), .busy_now(busy_now),
        .mpu_transfer(mpuTransfer2), .frame_valid(frameValid2), .frame_data(frameData2),
        .frame_count(frameCount2), .sample_overrun(sampleOverrun2),
        .timeout_err(timeoutErr2), .busy(busyOut2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [95:0] actual, input logic [95:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic stepCycle();
        @(negedge clk);
        cyc++;
    endtask

    // Leaves cyc = 0 on the first cycle the main instance is in CAPTURE.
    task automatic waitTransfer(input string tag, input int budget);
        int n = 0;
        do begin
            stepCycle();
            n++;
        end while (mpuTransfer !== 1'b1 && n < budget);
        if (mpuTransfer !== 1'b1) checkOutput(tag, 96'd0, 96'd1);
        cyc = 0;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        data_avalid = 1'b1;
        data        = b;
        stepCycle();
        data_avalid = 1'b0;
    endtask

    task automatic feedBytes(input logic [7:0] first, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            applyStimulus(first + 8'(i));
            if (i != n - 1) repeat (gap - 1) stepCycle();
        end
    endtask

    function automatic logic [95:0] makeFrame(input logic [7:0] first);
        logic [95:0] f;
        for (int i = 0; i < 12; i++) f[95-8*i -: 8] = first + 8'(i);
        return f;
    endfunction

    initial begin
        int ovCount, ovAt, fvCount, earlyXfer, sawXfer, sawFv, sawOv;
        rst_n = 1'b0; init_done = 1'b0; enable = 1'b0;
        data_avalid = 1'b0; data = 8'h00; busy_now = 1'b0;
        repeat (2) stepCycle();
        checkOutput("rst_transfer", mpuTransfer, 0);
        checkOutput("rst_data", frameData, 0);
        checkOutput("rst_count", frameCount, 0);
        checkOutput("rst_pulses", {frameValid, sampleOverrun, timeoutErr, busyOut}, 0);
        rst_n = 1'b1;
        repeat (3) stepCycle();
        checkOutput("wait_init_busy", busyOut, 0);

        // Normal frame
        init_done = 1'b1; enable = 1'b1;
        waitTransfer("normal_start", 150);
        checkOutput("normal_busy", busyOut, 1);
        feedBytes(8'h01, 12, 3);
        checkOutput("normal_valid", frameValid, 1);
        checkOutput("normal_data", frameData, 96'h0102030405060708090A0B0C);
        checkOutput("normal_count", frameCount, 1);
        checkOutput("normal_xfer_drop", mpuTransfer, 0);
        stepCycle();
        checkOutput("normal_single_pulse", frameValid, 0);
        checkOutput("normal_idle", busyOut, 0);

        // Timeout with only 5 bytes
        busy_now = 1'b1;
        waitTransfer("timeout_start", 150);
        feedBytes(8'h31, 5, 3);
        while (timeoutErr !== 1'b1 && cyc < 70) stepCycle();
        checkOutput("timeout_cycle", 96'(cyc), 50);
        checkOutput("timeout_xfer", mpuTransfer, 0);
        checkOutput("abort_busy", busyOut, 1);
        repeat (20) stepCycle();
        checkOutput("abort_hold", busyOut, 1);
        checkOutput("timeout_single_pulse", timeoutErr, 0);
        busy_now = 1'b0;
        stepCycle();
        checkOutput("abort_exit", busyOut, 0);
        checkOutput("abort_data_kept", frameData, 96'h0102030405060708090A0B0C);
        checkOutput("abort_count_kept", frameCount, 1);

        // Overrun on the long-timeout instance
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        begin
            int n = 0;
            do begin stepCycle(); n++; end while (mpuTransfer2 !== 1'b1 && n < 150);
            if (mpuTransfer2 !== 1'b1) checkOutput("overrun_start", 96'd0, 96'd1);
        end
        cyc = 0; ovCount = 0; ovAt = -1;
        while (cyc < 120) begin
            stepCycle();
            if (sampleOverrun2) begin ovCount++; ovAt = cyc; end
        end
        checkOutput("overrun_count", 96'(ovCount), 1);
        checkOutput("overrun_cycle", 96'(ovAt), 100);
        feedBytes(8'h41, 12, 3);
        checkOutput("overrun_frame_valid", frameValid2, 1);
        checkOutput("overrun_frame_data", frameData2, makeFrame(8'h41));
        fvCount = 0; earlyXfer = 0;
        while (cyc < 199) begin
            stepCycle();
            if (frameValid2) fvCount++;
            if (mpuTransfer2) earlyXfer++;
        end
        checkOutput("overrun_no_second_valid", 96'(fvCount), 0);
        checkOutput("overrun_no_early_capture", 96'(earlyXfer), 0);
        stepCycle();
        checkOutput("overrun_next_capture", mpuTransfer2, 1);

        // Disabled with stray bytes, then enable dropped mid-capture
        rst_n = 1'b0; enable = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        sawXfer = 0; sawFv = 0; sawOv = 0;
        for (int k = 0; k < 250; k++) begin
            data_avalid = (k % 7 == 0);
            data = 8'hEE;
            stepCycle();
            if (mpuTransfer) sawXfer++;
            if (frameValid) sawFv++;
            if (sampleOverrun) sawOv++;
        end
        data_avalid = 1'b0;
        checkOutput("disabled_no_xfer", 96'(sawXfer), 0);
        checkOutput("disabled_no_valid", 96'(sawFv), 0);
        checkOutput("disabled_no_overrun", 96'(sawOv), 0);
        enable = 1'b1;
        waitTransfer("enable_start", 150);
        feedBytes(8'h11, 6, 3);
        enable = 1'b0;
        repeat (2) stepCycle();
        feedBytes(8'h17, 6, 3);
        checkOutput("enable_drop_valid", frameValid, 1);
        checkOutput("enable_drop_data", frameData, makeFrame(8'h11));
        checkOutput("enable_drop_count", frameCount, 1);

        // Reset mid-capture
        enable = 1'b1;
        stepCycle();
        waitTransfer("reset_start", 150);
        feedBytes(8'hA1, 6, 3);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_outputs", {mpuTransfer, frameValid, busyOut, sampleOverrun, timeoutErr}, 0);
        checkOutput("midrst_data", frameData, 0);
        checkOutput("midrst_count", frameCount, 0);
        stepCycle();
        rst_n = 1'b1;
        waitTransfer("postrst_start", 150);
        feedBytes(8'h21, 12, 3);
        checkOutput("postrst_valid", frameValid, 1);
        checkOutput("postrst_data", frameData, makeFrame(8'h21));
        checkOutput("postrst_count", frameCount, 1);

        // init_done dropped mid-capture
        stepCycle();
        waitTransfer("initdrop_start", 150);
        feedBytes(8'h51, 3, 3);
        init_done = 1'b0;
        stepCycle();
        checkOutput("initdrop_xfer", mpuTransfer, 0);
        checkOutput("initdrop_busy", busyOut, 0);
        checkOutput("initdrop_count", frameCount, 1);
        checkOutput("initdrop_data", frameData, makeFrame(8'h21));
        repeat (3) stepCycle();
        init_done = 1'b1;
        stepCycle();

        // Frame counter wrap
        force u_dut.frame_count = 16'hFFFF;
        stepCycle();
        release u_dut.frame_count;
        stepCycle();
        checkOutput("wrap_preset", frameCount, 16'hFFFF);
        waitTransfer("wrap_start", 150);
        feedBytes(8'h61, 12, 3);
        checkOutput("wrap_valid", frameValid, 1);
        checkOutput("wrap_count", frameCount, 0);

        // Final byte lands in the same cycle as the timeout
        stepCycle();
        waitTransfer("coincide_start", 150);
        feedBytes(8'h71, 11, 1);
        while (cyc < 49) stepCycle();
        applyStimulus(8'h7C);
        checkOutput("coincide_valid", frameValid, 1);
        checkOutput("coincide_no_timeout", timeoutErr, 0);
        checkOutput("coincide_data", frameData, makeFrame(8'h71));
        checkOutput("coincide_count", frameCount, 1);
        stepCycle();
        checkOutput("coincide_idle", busyOut, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
